// File: rtl/uart_word64_tx_pkg.sv
// Shared types and constants for the 64-bit word UART transmitter.
// UART_WORD64_TX_CHECKSUM_EN adds a ninth XOR-checksum frame per word.
package uart_word64_tx_pkg;

    localparam int FRAME_BITS     = 10;
    localparam int BYTES_PER_WORD = 8;

`ifdef UART_WORD64_TX_CHECKSUM_EN
    localparam int FRAMES_PER_WORD = BYTES_PER_WORD + 1;
`else
    localparam int FRAMES_PER_WORD = BYTES_PER_WORD;
`endif

    typedef enum logic {
        TOP_IDLE,
        TOP_SEND
    } top_state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_e;

endpackage

// File: rtl/uart_word64_tx_tx_byte.sv
// 8N1 byte serializer; tx_ready also rises in the last stop-bit cycle so
// the next frame can start with no idle gap.
module uart_tx_byte
    import uart_word64_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_txd
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    ser_state_e        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        data_q, data_d;
    logic              txd_q, txd_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign tx_ready = (state_q == SER_IDLE) || ((state_q == SER_STOP) && baud_end);
    assign uart_txd = txd_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d = state_q;
        bit_d   = bit_q;
        data_d  = data_q;
        txd_d   = txd_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;

        case (state_q)
            SER_IDLE: baud_d = '0;
            SER_START: begin
                if (baud_end) begin
                    state_d = SER_DATA;
                    bit_d   = 3'd0;
                    txd_d   = data_q[0];
                end
            end
            SER_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = SER_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        data_d = {1'b0, data_q[7:1]};
                        txd_d  = data_q[1];
                    end
                end
            end
            SER_STOP: begin
                if (baud_end) state_d = SER_IDLE;
            end
            default: state_d = SER_IDLE;
        endcase

        // A handshake overrides the stop-bit exit, chaining frames back-to-back.
        if (tx_valid && tx_ready) begin
            state_d = SER_START;
            data_d  = tx_data;
            baud_d  = '0;
            bit_d   = 3'd0;
            txd_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            data_q  <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/uart_word64_tx.sv
// Sends a 64-bit word as eight back-to-back 8N1 frames, MSB byte first.
// Define UART_WORD64_TX_CHECKSUM_EN to append an XOR-of-bytes ninth frame.
module uart_word64_tx
    import uart_word64_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        uart_txd,
    output logic        busy,
    output logic [3:0]  byte_idx
);

    localparam logic [3:0] FRAMES_N = 4'(FRAMES_PER_WORD);

    top_state_e  state_q, state_d;
    logic [63:0] shift_q, shift_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [3:0]  sent_q, sent_d;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_fire, all_sent;

    assign all_sent   = (sent_q == FRAMES_N);
    assign tx_valid   = (state_q == TOP_SEND) && !all_sent;
    assign tx_fire    = tx_valid && tx_ready;
    assign word_ready = (state_q == TOP_IDLE);
    assign busy       = !word_ready;
    assign byte_idx   = byte_idx_q;

`ifdef UART_WORD64_TX_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
    assign tx_data = (sent_q == 4'(BYTES_PER_WORD)) ? xor_q : shift_q[63:56];
`else
    assign tx_data = shift_q[63:56];
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        sent_d     = sent_q;
`ifdef UART_WORD64_TX_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            TOP_IDLE: begin
                if (word_valid) begin
                    state_d    = TOP_SEND;
                    shift_d    = word_in;
                    byte_idx_d = 4'd0;
                    sent_d     = 4'd0;
`ifdef UART_WORD64_TX_CHECKSUM_EN
                    xor_d      = 8'h00;
`endif
                end
            end
            TOP_SEND: begin
                // byte_idx follows the frame whose start bit begins on this edge.
                if (tx_fire) begin
                    shift_d    = {shift_q[55:0], 8'h00};
                    sent_d     = sent_q + 4'd1;
                    byte_idx_d = sent_q;
`ifdef UART_WORD64_TX_CHECKSUM_EN
                    xor_d      = xor_q ^ shift_q[63:56];
`endif
                end else if (all_sent && tx_ready) begin
                    state_d = TOP_IDLE;
                end
            end
            default: state_d = TOP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TOP_IDLE;
            shift_q    <= 64'h0;
            byte_idx_q <= 4'd0;
            sent_q     <= 4'd0;
`ifdef UART_WORD64_TX_CHECKSUM_EN
            xor_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            sent_q     <= sent_d;
`ifdef UART_WORD64_TX_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_txd (uart_txd)
    );

endmodule

// File: tb/tb_uart_word64_tx.sv
// Self-checking bench: a behavioural UART receiver decodes the line and is
// compared with bytes/timestamps derived directly from the accepted words.
module tb_uart_word64_tx;
    import uart_word64_tx_pkg::*;

    localparam int C        = 4;
    localparam int N        = FRAMES_PER_WORD;
    localparam int FRAME_CY = FRAME_BITS * C;
    localparam int WORD_CY  = N * FRAME_CY;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        uart_txd;
    logic        busy;
    logic [3:0]  byte_idx;

    uart_word64_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .byte_idx   (byte_idx)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_idx[$];
    int         acc_q[$];
    int         rise_q[$];
    logic [7:0] exp_q[$];
    int         rx_err   = 0;
    int         busy_err = 0;
    int         rx_pos   = -1;
    int         rx_start = 0;
    logic [7:0] rx_sh    = 8'h00;
    logic       prev_ready = 1'b1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line receiver and handshake/ready-edge logger, all sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (busy !== ~word_ready) busy_err++;
        if (rst) begin
            rx_pos     = -1;
            prev_ready = 1'b1;
        end else begin
            if (word_valid && word_ready) acc_q.push_back(cyc + 1);
            if (word_ready && !prev_ready) rise_q.push_back(cyc);
            prev_ready = word_ready;
            if (rx_pos < 0 && uart_txd === 1'b0) begin
                rx_pos   = 0;
                rx_start = cyc;
                rx_idx.push_back(int'(byte_idx));
            end
            if (rx_pos >= 0) begin
                if (rx_pos % C == C / 2) begin
                    if (rx_pos / C == 0) begin
                        if (uart_txd !== 1'b0) rx_err++;
                    end else if (rx_pos / C <= 8) begin
                        rx_sh[rx_pos / C - 1] = uart_txd;
                    end else begin
                        if (uart_txd !== 1'b1) rx_err++;
                        rx_q.push_back(rx_sh);
                        rx_t.push_back(rx_start);
                    end
                end
                rx_pos++;
                if (rx_pos == FRAME_CY) rx_pos = -1;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_accept();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (word_valid && word_ready && !rst) got = 1'b1;
        end
        check("accept_timeout", got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (word_ready && rx_pos < 0) got = 1'b1;
        end
        check("idle_timeout", got, 1'b1);
        tick(2 * FRAME_CY);
    endtask

    // Reference: frame k carries byte k of the word, MSB byte first, plus optional XOR.
    task automatic push_expected(input logic [63:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            exp_q.push_back(w[63 - 8 * k -: 8]);
            x = x ^ w[63 - 8 * k -: 8];
        end
        if (N > BYTES_PER_WORD) exp_q.push_back(x);
    endtask

    task automatic clear_all();
        rx_q.delete();
        rx_t.delete();
        rx_idx.delete();
        acc_q.delete();
        rise_q.delete();
        exp_q.delete();
    endtask

    task automatic check_stream(input string tag, input int nwords);
        check({tag, "_frames"}, rx_q.size(), exp_q.size());
        check({tag, "_accepts"}, acc_q.size(), nwords);
        check({tag, "_rises"}, rise_q.size(), nwords);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
            check($sformatf("%s_idx%0d", tag, i), rx_idx[i], i % N);
            if (i / N < acc_q.size())
                check($sformatf("%s_start%0d", tag, i), rx_t[i],
                      acc_q[i / N] + 1 + (i % N) * FRAME_CY);
        end
        for (int j = 0; j < acc_q.size() && j < rise_q.size(); j++)
            check($sformatf("%s_ready%0d", tag, j), rise_q[j], acc_q[j] + 1 + WORD_CY);
        clear_all();
    endtask

    initial begin
        logic [63:0] w;

        rst        = 1'b1;
        word_valid = 1'b0;
        word_in    = 64'h0;
        tick(3);
        check("rst_txd", uart_txd, 1'b1);
        check("rst_ready", word_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_idx", byte_idx, 4'd0);
        rst = 1'b0;
        tick(2);

        // Single word; word_in is scrambled after accept and must not matter.
        word_in    = 64'h0123456789ABCDEF;
        word_valid = 1'b1;
        wait_accept();
        word_valid = 1'b0;
        word_in    = {$urandom, $urandom};
        push_expected(64'h0123456789ABCDEF);
        wait_idle();
        check_stream("single", 1);

        // Busy rejection.
        w          = 64'h8BAD_F00D_1234_5678;
        word_in    = w;
        word_valid = 1'b1;
        wait_accept();
        word_valid = 1'b0;
        tick(40);
        word_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        word_valid = 1'b1;
        tick(150);
        word_valid = 1'b0;
        push_expected(w);
        wait_idle();
        check_stream("busy_rej", 1);

        // Back-to-back with valid held: exactly one ready-high cycle between words.
        word_in    = 64'h1111111111111111;
        word_valid = 1'b1;
        wait_accept();
        word_in    = 64'h2222222222222222;
        wait_accept();
        word_valid = 1'b0;
        push_expected(64'h1111111111111111);
        push_expected(64'h2222222222222222);
        wait_idle();
        if (acc_q.size() > 1 && rise_q.size() > 0)
            check("b2b_gap", acc_q[1], rise_q[0] + 1);
        check_stream("b2b", 2);

        // Random words with random producer gaps.
        for (int j = 0; j < 4; j++) begin
            w          = {$urandom, $urandom};
            word_in    = w;
            word_valid = 1'b1;
            push_expected(w);
            wait_accept();
            word_valid = 1'b0;
            tick($urandom_range(0, 5));
        end
        wait_idle();
        check_stream("rand", 4);

        // Reset during frame 3 DATA, then a clean word from byte 0.
        word_in    = 64'hDEADBEEF_CAFEF00D;
        word_valid = 1'b1;
        wait_accept();
        word_valid = 1'b0;
        tick(1 + 3 * FRAME_CY + 3 * C);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_txd", uart_txd, 1'b1);
        check("midrst_ready", word_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_idx", byte_idx, 4'd0);
        tick(1);
        rst = 1'b0;
        check("midrst_partial", rx_q.size(), 3);
        if (rx_q.size() > 2) begin
            check("midrst_b0", rx_q[0], 8'hDE);
            check("midrst_b2", rx_q[2], 8'hBE);
        end
        clear_all();
        tick(5);
        word_in    = 64'hA5A5A5A5A5A5A5A5;
        word_valid = 1'b1;
        wait_accept();
        word_valid = 1'b0;
        push_expected(64'hA5A5A5A5A5A5A5A5);
        wait_idle();
        check_stream("after_rst", 1);

`ifdef UART_WORD64_TX_CHECKSUM_EN
        word_in    = 64'h00000000000000FF;
        word_valid = 1'b1;
        wait_accept();
        word_valid = 1'b0;
        push_expected(64'h00000000000000FF);
        wait_idle();
        if (rx_q.size() > 8) check("csum_frame8", rx_q[8], 8'hFF);
        if (acc_q.size() > 0 && rise_q.size() > 0)
            check("csum_ready361", rise_q[0] - acc_q[0], 361);
        check_stream("csum", 1);
`endif

        check("framing_errors", rx_err, 0);
        check("busy_vs_ready", busy_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
